// File: rtl/uart_apb_master.sv
// UART-to-APB bridge: parses 0x57 (write) / 0x52 (read) host commands from a
// received byte stream, runs one APB transfer, and streams back status/read data.
module uart_apb_master #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [31:0]       apb_pwdata,
  input  logic [31:0]       apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_SETUP, S_ACCESS, S_RESP
  } state_t;

  localparam logic [7:0]  CMD_WR   = 8'h57;
  localparam logic [7:0]  CMD_RD   = 8'h52;
  localparam logic [7:0]  ST_OK    = 8'h06;
  localparam logic [7:0]  ST_ERR   = 8'h15;
  localparam logic [7:0]  ST_TMO   = 8'h18;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         tmo_q, tmo_d;
  logic [7:0]          status_q, status_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          last_idx;

  // Only a successful read carries the four data bytes after the status.
  assign last_idx = (!wr_q && status_q == ST_OK) ? 3'd4 : 3'd0;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == CMD_WR) begin
          wr_d    = 1'b1;
          state_d = S_ADDR;
        end else if (rx_valid && rx_data == CMD_RD) begin
          wr_d    = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          paddr_d = rx_data[ADDR_W-1:0];
          cnt_d   = 2'd0;
          state_d = wr_q ? S_WDATA : S_SETUP;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          pwdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmo_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (apb_pready) begin
          status_d = apb_pslverr ? ST_ERR : ST_OK;
          if (!wr_q) rdata_d = apb_prdata;
          idx_d   = 3'd0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            status_d = ST_TMO;
            idx_d    = 3'd0;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          if (idx_q == last_idx) state_d = S_IDLE;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_q == S_RESP) begin
      case (idx_q)
        3'd0:    tx_data = status_q;
        3'd1:    tx_data = rdata_q[7:0];
        3'd2:    tx_data = rdata_q[15:8];
        3'd3:    tx_data = rdata_q[23:16];
        default: tx_data = rdata_q[31:24];
      endcase
    end
  end

  assign tx_valid    = (state_q == S_RESP);
  assign apb_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apb_penable = (state_q == S_ACCESS);
  assign apb_pwrite  = wr_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: one instance with an 8-cycle timeout and
// one with the timeout disabled, sharing every input.
module tb_uart_apb_master;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  logic        tx_valid, psel, penable, pwrite, busy;
  logic [7:0]  tx_data;
  logic [4:0]  paddr;
  logic [31:0] pwdata;

  logic        z_tx_valid, z_psel, z_penable, z_pwrite, z_busy;
  logic [7:0]  z_tx_data;
  logic [4:0]  z_paddr;
  logic [31:0] z_pwdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_apb_master #(.ADDR_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst_b(rst_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_prdata(prdata),
    .apb_pready(pready), .apb_pslverr(pslverr), .busy(busy)
  );

  uart_apb_master #(.ADDR_W(5), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_b(rst_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(z_tx_valid), .tx_data(z_tx_data), .tx_ready(tx_ready),
    .apb_psel(z_psel), .apb_penable(z_penable), .apb_pwrite(z_pwrite),
    .apb_paddr(z_paddr), .apb_pwdata(z_pwdata), .apb_prdata(prdata),
    .apb_pready(pready), .apb_pslverr(pslverr), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) tick();
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, tx_valid, tx_data, busy} !== 50'h0) begin
      bad++;
      $display("FAIL reset_outputs got psel=%b pen=%b pw=%b addr=%h wd=%h txv=%b txd=%h busy=%b exp all 0",
               psel, penable, pwrite, paddr, pwdata, tx_valid, tx_data, busy);
    end
    total++;
    if (z_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_t0 got %b exp 0", z_busy); end
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_write_zero_wait();
    pready = 1'b1;
    send_byte(8'h57); send_byte(8'h0C); send_byte(8'h78);
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    total++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 5'h0C, 32'h12345678}) begin
      bad++;
      $display("FAIL wr_setup got psel=%b pen=%b pw=%b addr=%h wd=%h exp 1 0 1 0c 12345678",
               psel, penable, pwrite, paddr, pwdata);
    end
    tick();
    total++;
    if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL wr_access got %b exp 11", {psel, penable}); end
    tick();
    total++;
    if ({psel, penable, tx_valid, tx_data} !== {1'b0, 1'b0, 1'b1, 8'h06}) begin
      bad++;
      $display("FAIL wr_resp got psel=%b pen=%b txv=%b txd=%h exp 0 0 1 06", psel, penable, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    total++;
    if ({busy, tx_valid} !== 2'b00) begin bad++; $display("FAIL wr_idle got busy/txv=%b exp 00", {busy, tx_valid}); end
    pready = 1'b0;
  endtask

  task automatic test_read_wait();
    logic [7:0] exp [5] = '{8'h06, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int n = 0;
    int pw_bad = 0;
    pready = 1'b0;
    prdata = 32'hDEADBEEF;
    send_byte(8'h52); send_byte(8'h04);
    total++;
    if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b0, 1'b0, 5'h04}) begin
      bad++;
      $display("FAIL rd_setup got psel=%b pen=%b pw=%b addr=%h exp 1 0 0 04", psel, penable, pwrite, paddr);
    end
    tick();
    while (penable === 1'b1 && n < 20) begin
      n++;
      if (pwrite !== 1'b0) pw_bad++;
      if (n == 4) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    total++;
    if (n !== 4) begin bad++; $display("FAIL rd_access_len got %0d exp 4", n); end
    total++;
    if (pw_bad !== 0) begin bad++; $display("FAIL rd_pwrite got %0d high cycles exp 0", pw_bad); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL rd_byte%0d got v=%b d=%h exp 1 %h", i, tx_valid, tx_data, exp[i]);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rd_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_slave_error();
    logic [7:0] exp [5] = '{8'h06, 8'h44, 8'h33, 8'h22, 8'h11};
    pready  = 1'b1;
    pslverr = 1'b1;
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    total++;
    if (paddr !== 5'h1F) begin bad++; $display("FAIL err_paddr got %h exp 1f", paddr); end
    tick(); tick();
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h15}) begin
      bad++; $display("FAIL err_status got v=%b d=%h exp 1 15", tx_valid, tx_data);
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL err_single got busy=%b exp 0", busy); end
    pready  = 1'b0;
    prdata  = 32'h11223344;
    send_byte(8'h52); send_byte(8'h01);
    tick(); tick();
    pslverr = 1'b0;
    pready  = 1'b1;
    tick();
    pready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL err_ignored_byte%0d got v=%b d=%h exp 1 %h", i, tx_valid, tx_data, exp[i]);
      end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [5] = '{8'h06, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    int n = 0;
    pready = 1'b0;
    send_byte(8'h52); send_byte(8'h10);
    tick();
    while (penable === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n !== 8) begin bad++; $display("FAIL tmo_len got %0d exp 8", n); end
    total++;
    if ({psel, penable, tx_valid, tx_data} !== {1'b0, 1'b0, 1'b1, 8'h18}) begin
      bad++;
      $display("FAIL tmo_resp got psel=%b pen=%b txv=%b txd=%h exp 0 0 1 18", psel, penable, tx_valid, tx_data);
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL tmo_single got busy=%b exp 0", busy); end
    repeat (30) tick();
    total++;
    if ({z_psel, z_penable, z_tx_valid} !== 3'b110) begin
      bad++; $display("FAIL tmo0_wait got psel/pen/txv=%b exp 110", {z_psel, z_penable, z_tx_valid});
    end
    prdata = 32'hCAFEF00D;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({z_tx_valid, z_tx_data} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL tmo0_byte%0d got v=%b d=%h exp 1 %h", i, z_tx_valid, z_tx_data, exp[i]);
      end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    total++;
    if ({busy, z_busy} !== 2'b00) begin bad++; $display("FAIL tmo_both_idle got %b exp 00", {busy, z_busy}); end
  endtask

  task automatic test_parsing();
    logic [7:0] exp [5] = '{8'h06, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    pready = 1'b1;
    prdata = 32'h0A0B0C0D;
    send_byte(8'h41);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL parse_junk got busy=%b exp 0", busy); end
    send_byte(8'h52); send_byte(8'h08);
    total++;
    if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b0, 1'b0, 5'h08}) begin
      bad++;
      $display("FAIL parse_setup got psel=%b pen=%b pw=%b addr=%h exp 1 0 0 08", psel, penable, pwrite, paddr);
    end
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({tx_valid, tx_data} !== {1'b1, exp[i]}) begin
        bad++;
        $display("FAIL parse_byte%0d got v=%b d=%h exp 1 %h", i, tx_valid, tx_data, exp[i]);
      end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    pready = 1'b0;
    prdata = 32'h55667788;
    send_byte(8'h52); send_byte(8'h02);
    tick();
    send_byte(8'h57);
    total++;
    if ({psel, penable, pwrite} !== 3'b110) begin
      bad++; $display("FAIL parse_rx_in_access got psel/pen/pw=%b exp 110", {psel, penable, pwrite});
    end
    pready = 1'b1; tick(); pready = 1'b0;
    send_byte(8'h52);
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin
      bad++; $display("FAIL parse_rx_in_resp got v=%b d=%h exp 1 06", tx_valid, tx_data);
    end
    repeat (5) begin tx_ready = 1'b1; tick(); tx_ready = 1'b0; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL parse_drain got busy=%b exp 0", busy); end
    pready = 1'b1;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    total++;
    if ({psel, pwrite, paddr, pwdata} !== {1'b1, 1'b1, 5'h03, 32'hDDCCBBAA}) begin
      bad++;
      $display("FAIL parse_next_wr got psel=%b pw=%b addr=%h wd=%h exp 1 1 03 ddccbbaa", psel, pwrite, paddr, pwdata);
    end
    tick(); tick();
    total++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h06}) begin
      bad++; $display("FAIL parse_next_status got v=%b d=%h exp 1 06", tx_valid, tx_data);
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    pready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [5] = '{8'h06, 8'h21, 8'h43, 8'h65, 8'h87};
    logic [7:0] exp2 [5] = '{8'h06, 8'h04, 8'h03, 8'h02, 8'h01};
    int badc;
    pready = 1'b1;
    prdata = 32'h87654321;
    send_byte(8'h52); send_byte(8'h05);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      badc = 0;
      for (int c = 0; c < 10; c++) begin
        if ({tx_valid, tx_data} !== {1'b1, exp[i]}) badc++;
        tick();
      end
      total++;
      if (badc !== 0) begin
        bad++; $display("FAIL bp_byte%0d got %0d unstable cycles, last d=%h exp %h", i, badc, tx_data, exp[i]);
      end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got busy=%b exp 0", busy); end
    send_byte(8'h57); send_byte(8'h0C); send_byte(8'h78);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, tx_valid, tx_data, busy} !== 50'h0) begin
      bad++;
      $display("FAIL rst_mid got psel=%b pen=%b pw=%b addr=%h wd=%h txv=%b txd=%h busy=%b exp all 0",
               psel, penable, pwrite, paddr, pwdata, tx_valid, tx_data, busy);
    end
    prdata = 32'h01020304;
    send_byte(8'h52); send_byte(8'h06);
    total++;
    if ({psel, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 5'h06, 32'h0}) begin
      bad++;
      $display("FAIL rst_next_setup got psel=%b pw=%b addr=%h wd=%h exp 1 0 06 00000000", psel, pwrite, paddr, pwdata);
    end
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({tx_valid, tx_data} !== {1'b1, exp2[i]}) begin
        bad++;
        $display("FAIL rst_next_byte%0d got v=%b d=%h exp 1 %h", i, tx_valid, tx_data, exp2[i]);
      end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    pready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_parsing();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
- Bridge that turns a UART byte stream into APB transactions. It is the APB initiator that sits opposite memory-mapped UART-style APB responders.
- Consumes received bytes from the rx side of a uart_core (rx_valid/rx_data) and parses host commands.
- Runs one APB read or write per command.
- Returns a status byte, plus read data for reads, through the tx side of uart_core (tx_valid/tx_data/tx_ready).
- Used as a host debug port into the APB peripheral space.

Parameters:
- ADDR_W, 5: APB address width. Taken from the low ADDR_W bits of the address byte, with 1 <= ADDR_W <= 8.
- TIMEOUT, 255: maximum number of ACCESS-phase cycles before the transfer is aborted. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset
- rx_valid  in  1  one-cycle pulse; a received byte is present on rx_data
- rx_data  in  8  received byte
- tx_valid  out  1  response byte valid
- tx_data  out  8  response byte
- tx_ready  in  1  uart_core accepts the tx byte
- apb_psel  out  1  APB select
- apb_penable  out  1  APB enable
- apb_pwrite  out  1  1 = write
- apb_paddr  out  ADDR_W  APB address
- apb_pwdata  out  32  APB write data
- apb_prdata  in  32  APB read data
- apb_pready  in  1  APB ready
- apb_pslverr  in  1  APB slave error
- busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: single clock clk. Reset rst_b is synchronous and active-low.
- Values while rst_b=0: every output is 0, the state is IDLE, the byte counter is 0, and any partial command or response is discarded.
- Command format, one byte per rx_valid pulse:
  - Write: 0x57, ADDR, D0, D1, D2, D3. Data is little-endian, so pwdata = {D3,D2,D1,D0}.
  - Read: 0x52, ADDR.
- States: IDLE, ADDR, WDATA, SETUP, ACCESS, RESP.
- IDLE:
  - rx 0x57 sets the write flag and goes to ADDR.
  - rx 0x52 clears the write flag and goes to ADDR.
  - Any other byte is silently dropped and the state stays IDLE.
- ADDR:
  - On rx_valid, latch paddr = rx_data[ADDR_W-1:0].
  - Write: go to WDATA with byte counter = 0.
  - Read: go to SETUP.
- WDATA:
  - Each rx_valid loads pwdata byte[counter] and increments the counter.
  - When the 4th byte arrives (counter==3), go to SETUP.
  - There is no inter-byte timeout.
- SETUP, exactly one cycle:
  - psel=1, penable=0.
  - pwrite, paddr and pwdata are valid and are held unchanged until psel falls.
  - Next state is ACCESS; the timeout counter clears.
- ACCESS:
  - psel=1, penable=1.
  - Completion on a cycle with pready=1:
    - capture prdata (reads only) and pslverr;
    - status = 0x15 if pslverr, else 0x06;
    - go to RESP.
  - Cycles with pready=0 increment the timeout counter.
  - Abort when TIMEOUT!=0, the counter equals TIMEOUT-1 and pready=0:
    - status = 0x18;
    - go to RESP;
    - ACCESS therefore lasts at most TIMEOUT cycles.
  - psel and penable are 0 in the cycle after completion or abort.
  - pslverr is ignored unless pready=1.
- RESP:
  - tx_valid=1 and tx_data = the current response byte. Both are held stable until tx_ready.
  - On tx_valid && tx_ready, advance to the next byte; the last byte returns to IDLE on the next cycle.
  - The next tx_valid follows on the cycle after acceptance, with no gap beyond that.
  - Response sequences:
    - write: status only;
    - read OK: 0x06 followed by prdata byte0..byte3 (LSB first), 5 bytes total;
    - read error (0x15 or 0x18): status only.
- Latency:
  - SETUP begins on the cycle after the final command byte's rx_valid.
  - tx_valid rises on the cycle after the ACCESS completion cycle.
- rx_valid pulses received in SETUP, ACCESS or RESP are dropped and have no effect on the current transaction.
- rx_valid and tx_ready may arrive together; each is handled by its own state and the rx byte is dropped if the state is RESP.

Test Plan:
1. Write with zero wait states:
   - Stimulus: rx 57 0C 78 56 34 12, pready tied 1.
   - Response: one SETUP cycle with psel=1, penable=0, pwrite=1, paddr=0x0C, pwdata=0x12345678; one ACCESS cycle; then tx 0x06, then IDLE with busy=0.
2. Read with wait states:
   - Stimulus: rx 52 04, pready low for 3 ACCESS cycles then high, prdata=0xDEADBEEF.
   - Response: ACCESS lasts 4 cycles; tx sequence 06 EF BE AD DE; pwrite=0 throughout.
3. Slave error:
   - Stimulus: write to 0x1F (ADDR_W=5, ADDR byte 0xFF) with pslverr=1 alongside pready.
   - Response: paddr=0x1F, single tx 0x15.
   - Stimulus: pslverr=1 while pready=0, then pslverr=0 with pready=1.
   - Response: 0x06.
4. Timeout:
   - Stimulus: TIMEOUT=8, read with pready never asserted.
   - Response: exactly 8 cycles with penable=1, psel/penable 0 on the next cycle, single tx 0x18.
   - Stimulus: TIMEOUT=0.
   - Response: waits indefinitely.
5. Parsing robustness:
   - Stimulus: rx 41 52 08.
   - Response: 0x41 is ignored and a read of 0x08 completes.
   - Stimulus: rx 57 during ACCESS.
   - Response: dropped, and the next command after IDLE parses correctly.
6. Backpressure and reset:
   - Stimulus: read response with tx_ready held low 10 cycles per byte.
   - Response: tx_data stable, all 5 bytes delivered in order.
   - Stimulus: rst_b=0 for one cycle after rx 57 0C 78.
   - Response: all outputs 0; a subsequent full read command works with no stale data.
